// File: rtl/serial_mul_stream.sv
`default_nettype none
// ============================================================================
// Module      : serial_mul_stream
// Description : Assembles operand pairs from MSD-first digit streams, queues
//               them in a small FIFO, multiplies them with a bit-serial
//               unsigned shift-add engine and streams the 2*WIDTH-bit product
//               out MSB chunk first over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mul_stream #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 4,
    parameter int DEPTH = 4,
    parameter int OUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIGIT-1:0]           in_a,
    input  logic [DIGIT-1:0]           in_b,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy
);

    localparam int c_NDIG   = WIDTH / DIGIT;
    localparam int c_CNT_W  = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FCNT_W = $clog2(DEPTH + 1);
    localparam int c_NCHUNK = (2 * WIDTH) / OUT_W;
    localparam int c_IDX_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam int c_BIT_W  = $clog2(WIDTH);

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(c_NDIG - 1);
    localparam logic [c_FCNT_W-1:0] c_FULL     = c_FCNT_W'(DEPTH);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(c_NCHUNK - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Loader state
    logic [c_CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]      r_asm_a;
    logic [WIDTH-1:0]      r_asm_b;

    // FIFO state
    logic [2*WIDTH-1:0]    r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_FCNT_W-1:0]   r_fcount;

    // Multiplier state
    state_t                r_state;
    logic [2*WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_acc;
    logic [c_BIT_W-1:0]    r_bit;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_out_valid;
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_last;

    logic                  w_last_digit;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [WIDTH-1:0]      w_asm_a_next;
    logic [WIDTH-1:0]      w_asm_b_next;
    logic [2*WIDTH-1:0]    w_head;

    // Ready only drops when the word-completing digit would hit a full FIFO;
    // it looks at registered occupancy, so a same-cycle pop cannot raise it.
    assign w_last_digit = (r_cnt == c_CNT_LAST);
    assign in_ready     = !(w_last_digit && (r_fcount == c_FULL));
    assign w_accept     = in_valid && in_ready && !abort;
    assign w_push       = w_accept && w_last_digit;
    assign w_pop        = (r_state == ST_IDLE) && (r_fcount != '0);
    assign w_asm_a_next = {r_asm_a[WIDTH-DIGIT-1:0], in_a};
    assign w_asm_b_next = {r_asm_b[WIDTH-DIGIT-1:0], in_b};
    assign w_head       = r_mem[r_rd_ptr];

    assign fifo_count   = r_fcount;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign busy         = (r_state != ST_IDLE);

    // Digit loader: shift digits in MSD first, abort wipes the partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_asm_a <= '0;
            r_asm_b <= '0;
        end else if (abort) begin
            r_cnt   <= '0;
            r_asm_a <= '0;
            r_asm_b <= '0;
        end else if (w_accept) begin
            if (w_last_digit) begin
                r_cnt   <= '0;
                r_asm_a <= '0;
                r_asm_b <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_asm_a <= w_asm_a_next;
                r_asm_b <= w_asm_b_next;
            end
        end
    end

    // FIFO storage: the completed pair is written including the final digit
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_asm_a_next, w_asm_b_next};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fcount <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_fcount <= r_fcount + 1'b1;
            else if (w_pop && !w_push) r_fcount <= r_fcount - 1'b1;
        end
    end

    // Multiplier FSM: pop, WIDTH shift-add steps, then chunked drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_head[2*WIDTH-1:WIDTH]};
                        r_mplier <= w_head[WIDTH-1:0];
                        r_acc    <= '0;
                        r_bit    <= '0;
                        r_state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_bit    <= r_bit + 1'b1;
                    if (r_bit == c_BIT_LAST) begin
                        r_idx   <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // First DRAIN cycle presents chunk 0; later ones advance
                    // only on an accepted handshake so data stays stable.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_acc[2*WIDTH-1 -: OUT_W];
                        r_acc       <= r_acc << OUT_W;
                        r_out_last  <= (r_idx == c_IDX_LAST);
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_out_data <= r_acc[2*WIDTH-1 -: OUT_W];
                            r_acc      <= r_acc << OUT_W;
                            r_out_last <= ((r_idx + 1'b1) == c_IDX_LAST);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_mul_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mul_stream
// Description : Directed self-checking bench for serial_mul_stream, default
//               configuration plus a small 8-bit configuration instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mul_stream;

    logic        clk;
    logic        rst;

    // Default-parameter instance
    logic        in_valid, in_ready, abort, out_valid, out_ready, out_last, busy;
    logic [3:0]  in_a, in_b;
    logic [7:0]  out_data;
    logic [2:0]  fifo_count;

    // Small-parameter instance
    logic        s_in_valid, s_in_ready, s_abort, s_out_valid, s_out_ready;
    logic        s_out_last, s_busy;
    logic [1:0]  s_in_a, s_in_b;
    logic [3:0]  s_out_data;
    logic [1:0]  s_fifo_count;

    int          n_checks;
    int          n_pass;

    serial_mul_stream u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    serial_mul_stream #(
        .WIDTH (8),
        .DIGIT (2),
        .DEPTH (2),
        .OUT_W (4)
    ) u_dut_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_a       (s_in_a),
        .in_b       (s_in_b),
        .abort      (s_abort),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .out_last   (s_out_last),
        .fifo_count (s_fifo_count),
        .busy       (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Offer digits first..last of an operand pair, MSD first
    task automatic send_digits(input logic [63:0] a, input logic [63:0] b,
                               input int first, input int last);
        for (int i = first; i <= last; i++) begin
            in_a     = 4'(a >> (4 * (15 - i)));
            in_b     = 4'(b >> (4 * (15 - i)));
            in_valid = 1'b1;
            for (int t = 0; t < 3000 && !in_ready; t++) @(negedge clk);
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [63:0] a, input logic [63:0] b);
        send_digits(a, b, 0, 15);
    endtask

    task automatic wait_valid(input int budget);
        for (int t = 0; t < budget && !out_valid; t++) @(negedge clk);
        check("valid_seen", out_valid, 1);
    endtask

    // Accept a full product with out_ready held high and compare all chunks
    task automatic collect(input logic [127:0] exp);
        out_ready = 1'b1;
        wait_valid(2000);
        for (int k = 0; k < 16; k++) begin
            check("chunk_valid", out_valid, 1);
            check("chunk_data", out_data, 8'(exp >> (8 * (15 - k))));
            check("chunk_last", out_last, (k == 15));
            @(negedge clk);
        end
        check("valid_after_last", out_valid, 0);
        check("data_after_last", out_data, 0);
    endtask

    initial begin
        int k;
        int nvalid;
        logic [15:0] s_prod;
        logic [7:0]  s_a8, s_b8;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; abort = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_abort = 1'b0; s_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3 * 5 with latency measured from the pop edge
        send_pair(64'h3, 64'h5);
        check("queued_one", fifo_count, 1);
        @(negedge clk);
        check("busy_after_pop", busy, 1);
        check("fifo_after_pop", fifo_count, 0);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 65);
        collect(128'h0F);

        // All-ones squared
        send_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        collect(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

        // Backpressure: six pairs with out_ready low
        out_ready = 1'b0;
        send_pair(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        send_pair(64'h2, 64'h3);
        send_pair(64'h10, 64'h10);
        send_pair(64'hFF, 64'hFF);
        send_pair(64'h1_0000_0000, 64'h1_0000_0000);
        send_digits(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 14);
        in_a = 4'h0; in_b = 4'h0; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_fifo_full", fifo_count, 4);
        check("bp_held_valid", out_valid, 1);
        check("bp_held_data", out_data, 8'hFF);
        check("bp_held_last", out_last, 0);
        fork
            send_digits(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 15, 15);
            begin
                collect(128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
                collect(128'h6);
                collect(128'h100);
                collect(128'hFE01);
                collect(128'h1_0000_0000_0000_0000);
                collect(128'h4000_0000_0000_0000_0000_0000_0000_0000);
            end
        join

        // Abort after seven digits, then 2 * 7
        send_digits(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6);
        in_a = 4'hF; in_b = 4'hF; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check("abort_fifo", fifo_count, 0);
        check("abort_busy", busy, 0);
        send_pair(64'h2, 64'h7);
        collect(128'h0E);

        // Reset mid-MUL with two queued pairs and a partial word
        send_pair(64'h3, 64'h5);
        send_pair(64'h3, 64'h5);
        send_pair(64'h3, 64'h5);
        send_digits(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_fifo", fifo_count, 2);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_fifo", fifo_count, 0);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_data", out_data, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 1);
        nvalid = 0;
        for (int t = 0; t < 150; t++) begin
            @(negedge clk);
            if (out_valid) nvalid++;
        end
        check("no_spurious_output", nvalid, 0);
        send_pair(64'h2, 64'h3);
        collect(128'h6);

        // Small configuration: 0xC8 * 0x0A = 0x07D0
        s_a8 = 8'hC8;
        s_b8 = 8'h0A;
        s_prod = 16'h07D0;
        for (int i = 0; i < 4; i++) begin
            s_in_a = 2'(s_a8 >> (2 * (3 - i)));
            s_in_b = 2'(s_b8 >> (2 * (3 - i)));
            s_in_valid = 1'b1;
            for (int t = 0; t < 100 && !s_in_ready; t++) @(negedge clk);
            if (!s_in_ready) check("s_in_ready_timeout", s_in_ready, 1);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        for (int t = 0; t < 100 && !s_out_valid; t++) @(negedge clk);
        check("s_valid_seen", s_out_valid, 1);
        for (int c = 0; c < 4; c++) begin
            check("s_chunk_data", s_out_data, 4'(s_prod >> (4 * (3 - c))));
            check("s_chunk_last", s_out_last, (c == 3));
            @(negedge clk);
        end
        check("s_valid_after_last", s_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_mul_stream.md
SERIAL_MUL_STREAM -- requirements
Module: serial_mul_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: input digit width; WIDTH SHALL be a multiple of DIGIT.
REQ-003 SHALL have parameter DEPTH, default 4: operand-pair FIFO depth; power of 2, at least 2.
REQ-004 SHALL have parameter OUT_W, default 8: output chunk width; 2*WIDTH SHALL be a multiple of OUT_W.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: digit pair present.
REQ-008 SHALL have port in_ready, output, 1: digit pair accepted this cycle if in_valid.
REQ-009 SHALL have ports in_a and in_b, input, DIGIT each: operand A and operand B digits, most significant digit first.
REQ-010 SHALL have port abort, input, 1: discard the partially assembled word.
REQ-011 SHALL have port out_valid, output, 1: product chunk present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts chunk.
REQ-013 SHALL have port out_data, output, OUT_W: product chunk, most significant chunk first.
REQ-014 SHALL have port out_last, output, 1: high with the final chunk of a product.
REQ-015 SHALL have port fifo_count, output, $clog2(DEPTH+1): occupied FIFO entries.
REQ-016 SHALL have port busy, output, 1: multiplier state not IDLE.

Function
REQ-017 Loader: a digit pair is accepted when in_valid and in_ready are both high; N = WIDTH/DIGIT digits form one operand pair; a digit counter wraps 0..N-1.
REQ-018 Each accepted digit SHALL shift into the assembly registers: asm = (asm << DIGIT) | digit.
REQ-019 in_ready SHALL be low only when the counter is N-1 and fifo_count == DEPTH; a pop in the same cycle SHALL NOT raise in_ready, so push-on-full is never attempted.
REQ-020 Acceptance of digit N-1 SHALL push {A,B} into the FIFO at that edge and clear the counter.
REQ-021 abort high SHALL clear the counter and the assembly registers and discard any digit offered that cycle; FIFO contents are unaffected; abort has priority over in_valid.
REQ-022 FIFO: circular buffer with wr/rd pointers wrapping modulo DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-023 Multiplier FSM states: IDLE, MUL, DRAIN.
REQ-024 IDLE with fifo_count>0 SHALL pop the head into A,B, clear the 2*WIDTH accumulator, and go to MUL.
REQ-025 MUL SHALL run exactly WIDTH cycles of unsigned shift-add (one multiplier bit per cycle), then go to DRAIN.
REQ-026 Product arithmetic SHALL be unsigned, full 2*WIDTH bits, with no truncation.
REQ-027 In DRAIN, out_valid SHALL be high and out_data SHALL equal the current chunk, held stable until out_ready; chunk index advances on each out_valid&&out_ready.
REQ-028 out_last SHALL be high only on chunk 2*WIDTH/OUT_W-1; its acceptance SHALL return the FSM to IDLE.
REQ-029 Latency: first out_valid SHALL occur exactly WIDTH+1 edges after the pop edge; a back-to-back next pop SHALL occur at the edge after out_last is accepted, when the FIFO is non-empty.
REQ-030 out_valid SHALL be low outside DRAIN; out_data SHALL be 0 when out_valid is low.

Reset
REQ-031 rst SHALL immediately force: FSM to IDLE; counter, pointers and fifo_count to 0; in_ready=1; out_valid=0; out_last=0; out_data=0; busy=0.
REQ-032 rst asserted mid-word, mid-MUL or mid-DRAIN SHALL discard all partial and queued data; no chunk SHALL appear after release until a new full word is loaded.

Verification
REQ-033 Defaults, A=0x3, B=0x5 (16 digits each), out_ready=1 -> 16 chunks 0x00...0x00,0x0F, out_last on the 16th, first out_valid 65 edges after the pop.
REQ-034 A=B=0xFFFFFFFFFFFFFFFF -> chunks FF x7, FE, 00 x7, 01.
REQ-035 out_ready=0, six pairs streamed -> pair 1 held in DRAIN, fifo_count=4, in_ready low at digit 16 of pair 6; out_ready=1 -> all six products emitted in order.
REQ-036 abort after 7 digits, then a full new pair A=2, B=7 -> single product 0x0E; the aborted digits have no effect.
REQ-037 rst pulsed during MUL with 2 entries queued -> fifo_count=0, out_valid=0 after release, no spurious output.
REQ-038 WIDTH=8, DIGIT=2, DEPTH=2, OUT_W=4, A=0xC8, B=0x0A -> chunks 0,7,D,0 with out_last on the 4th.
